// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer.
//   state_e          : sequencer FSM states (RUN, DRAIN, HALTED)
//   HALT_INST        : encoding of the halt instruction seen in ID
//   DRAIN_CYCLES_DEF : default number of drain cycles after a halt
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [31:0] HALT_INST        = 32'hFFFF_FFFF;
    localparam int          DRAIN_CYCLES_DEF = 3;

endpackage : pipe_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   i_ex_mem_read : instruction in EX is a load
//   i_ex_rt       : destination register of the load in EX
//   i_id_rs       : rs field of the instruction in ID
//   i_id_rt       : rt field of the instruction in ID
//   o_load_use    : ID consumes the register the EX load is writing
module hazard_detect (
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_load_use
);

    // Register $zero is never really written, so a load targeting it
    // cannot create a dependency.
    assign o_load_use = i_ex_mem_read
                      & (i_ex_rt != 5'd0)
                      & ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));

endmodule : hazard_detect

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: load-use stalls, branch flushes, halt/drain handling
// and performance counters for a classic 5-stage pipeline.
// Ports:
//   CLOCK, RESET         : rising-edge clock, asynchronous active-low reset
//   ID_Rs, ID_Rt         : source register fields of the ID instruction
//   Halt_D               : ID instruction is the halt encoding
//   EX_MemRead, EX_Rt    : load in EX and its destination register
//   BranchTaken_M        : branch resolved taken in MEM
//   PC_EN, IFID_EN       : write enables for PC and IF/ID
//   IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH : insert a bubble in that register
//   HALTED               : program complete (left only through RESET)
//   CycleCount           : executed cycles, saturating
//   StallCount           : load-use stalls taken, saturating
module pipeline_sequencer
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        Halt_D,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        BranchTaken_M,
    output logic        PC_EN,
    output logic        IFID_EN,
    output logic        IFID_FLUSH,
    output logic        IDEX_FLUSH,
    output logic        EXMEM_FLUSH,
    output logic        HALTED,
    output logic [31:0] CycleCount,
    output logic [15:0] StallCount
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [31:0]        r_cycle_cnt;
    logic [15:0]        r_stall_cnt;

    logic               w_load_use;
    logic               w_stall_inc;
    logic               w_load_drain;
    logic               w_cancel_drain;

    hazard_detect u_hazard_detect (
        .i_ex_mem_read (EX_MemRead),
        .i_ex_rt       (EX_Rt),
        .i_id_rs       (ID_Rs),
        .i_id_rt       (ID_Rt),
        .o_load_use    (w_load_use)
    );

    // Next state and control outputs. Priority inside RUN is
    // branch > load-use > halt; DRAIN only reacts to a branch.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves one unassigned, which would infer a latch.
        w_next_state   = r_state;
        PC_EN          = 1'b1;
        IFID_EN        = 1'b1;
        IFID_FLUSH     = 1'b0;
        IDEX_FLUSH     = 1'b0;
        EXMEM_FLUSH    = 1'b0;
        w_stall_inc    = 1'b0;
        w_load_drain   = 1'b0;
        w_cancel_drain = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (BranchTaken_M) begin
                    IFID_FLUSH  = 1'b1;
                    IDEX_FLUSH  = 1'b1;
                    EXMEM_FLUSH = 1'b1;
                end else if (w_load_use) begin
                    PC_EN       = 1'b0;
                    IFID_EN     = 1'b0;
                    IDEX_FLUSH  = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (Halt_D) begin
                    PC_EN        = 1'b0;
                    IFID_EN      = 1'b0;
                    w_load_drain = 1'b1;
                    w_next_state = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (BranchTaken_M) begin
                    // A taken branch ahead of the halt means the halt was on
                    // a wrong path: flush and resume fetching.
                    IFID_FLUSH     = 1'b1;
                    IDEX_FLUSH     = 1'b1;
                    EXMEM_FLUSH    = 1'b1;
                    w_cancel_drain = 1'b1;
                    w_next_state   = ST_RUN;
                end else begin
                    PC_EN      = 1'b0;
                    IFID_EN    = 1'b0;
                    IDEX_FLUSH = 1'b1;
                    // "<= 1" also terminates cleanly when DRAIN_CYCLES is 0.
                    if (r_drain_cnt <= CNT_W'(1)) begin
                        w_next_state = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                PC_EN       = 1'b0;
                IFID_EN     = 1'b0;
                IFID_FLUSH  = 1'b1;
                IDEX_FLUSH  = 1'b1;
                EXMEM_FLUSH = 1'b1;
            end

            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_drain_cnt <= '0;
        end else if (w_load_drain) begin
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
        end else if (w_cancel_drain) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_cycle_cnt <= '0;
        end else if (r_state != ST_HALTED && r_cycle_cnt != 32'hFFFF_FFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign HALTED     = (r_state == ST_HALTED);
    assign CycleCount = r_cycle_cnt;
    assign StallCount = r_stall_cnt;

endmodule : pipeline_sequencer

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, the number of drain cycles after a halt is accepted.
REQ-002 SHALL have port CLOCK, input, 1 bit, the single clock (rising edge).
REQ-003 SHALL have port RESET, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port ID_Rs, input, 5 bits, rs field of the instruction in ID.
REQ-005 SHALL have port ID_Rt, input, 5 bits, rt field of the instruction in ID.
REQ-006 SHALL have port Halt_D, input, 1 bit, set when the ID instruction equals 32'hFFFFFFFF.
REQ-007 SHALL have port EX_MemRead, input, 1 bit, set when the instruction in EX is a load.
REQ-008 SHALL have port EX_Rt, input, 5 bits, destination register of the load in EX.
REQ-009 SHALL have port BranchTaken_M, input, 1 bit, equal to the MEM-stage PCSrc.
REQ-010 SHALL have port PC_EN, output, 1 bit, PC register write enable.
REQ-011 SHALL have port IFID_EN, output, 1 bit, IF/ID register write enable.
REQ-012 SHALL have ports IFID_FLUSH, IDEX_FLUSH and EXMEM_FLUSH, outputs, 1 bit each, which load a bubble into the named register.
REQ-013 SHALL have port HALTED, output, 1 bit, sticky flag for "program complete".
REQ-014 SHALL have port CycleCount, output, 32 bits, the executed-cycle counter.
REQ-015 SHALL have port StallCount, output, 16 bits, the load-use stall counter.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN and HALTED.
REQ-017 SHALL compute LoadUse = EX_MemRead & (EX_Rt != 0) & (EX_Rt == ID_Rs | EX_Rt == ID_Rt).
REQ-018 SHALL drive control outputs combinationally from state and current inputs, with priority BranchTaken_M > LoadUse > Halt_D.
REQ-019 SHALL, in RUN with no event, drive PC_EN=1, IFID_EN=1 and all flushes 0.
REQ-020 SHALL, on BranchTaken_M in RUN or DRAIN, drive IFID_FLUSH, IDEX_FLUSH and EXMEM_FLUSH=1 and PC_EN=1 in the same cycle; the next state is RUN.
REQ-021 SHALL, on LoadUse in RUN without a branch, drive PC_EN=0, IFID_EN=0 and IDEX_FLUSH=1 for exactly that cycle, and increment StallCount.
REQ-022 SHALL, on Halt_D in RUN without a branch or LoadUse, drive PC_EN=0 and IFID_EN=0, load the drain counter with DRAIN_CYCLES and enter DRAIN next edge.
REQ-023 SHALL, in DRAIN, drive PC_EN=0, IFID_EN=0 and IDEX_FLUSH=1, and decrement the counter each edge; when counter==1 at an edge, the next state is HALTED.
REQ-024 SHALL, in HALTED, drive PC_EN=0, IFID_EN=0, all flushes 1 and HALTED=1; the only exit is RESET.
REQ-025 SHALL increment CycleCount on every edge not in HALTED, saturating at 32'hFFFFFFFF.
REQ-026 SHALL saturate StallCount at 16'hFFFF.
REQ-027 SHALL, on LoadUse coincident with BranchTaken_M, neither stall nor increment StallCount.
REQ-028 SHALL ignore Halt_D outside RUN and ignore LoadUse outside RUN.

Reset
REQ-029 SHALL, while RESET=0, asynchronously force state=RUN, drain counter=0, CycleCount=0, StallCount=0 and HALTED=0; outputs read PC_EN=1, IFID_EN=1 and flushes 0.
REQ-030 SHALL, when RESET is asserted mid-DRAIN or in HALTED, return to RUN with no residual flush or stall.
REQ-031 SHALL leave release synchronization to the top level.

Structure
REQ-032 SHALL place the state enum, HALT_INST=32'hFFFFFFFF and the DRAIN_CYCLES default in a shared package pipe_pkg.
REQ-033 SHALL isolate the LoadUse comparator in one combinational sub-module, hazard_detect.

Verification
REQ-034 SHALL cover load-use: lw $2 in EX with ID_Rs=2 -> one cycle of PC_EN=0, IFID_EN=0, IDEX_FLUSH=1, StallCount 0->1, then RUN.
REQ-035 SHALL cover the $zero case: EX_MemRead=1, EX_Rt=0, ID_Rs=0 -> no stall, StallCount unchanged.
REQ-036 SHALL cover a taken branch: BranchTaken_M=1 with LoadUse=1 -> all three flushes 1, PC_EN=1, StallCount unchanged.
REQ-037 SHALL cover halt: Halt_D=1 in RUN -> 3 DRAIN cycles, HALTED=1 on the 4th edge, CycleCount frozen thereafter.
REQ-038 SHALL cover halt cancel: Halt_D, then BranchTaken_M=1 in the first DRAIN cycle -> flushes asserted, state RUN, HALTED=0.
REQ-039 SHALL cover reset mid-DRAIN: RESET=0 asynchronously -> counters 0, HALTED=0, PC_EN=1 immediately.
